// File: rtl/ccc_ce_divider_pkg.sv
// ccc_pkg: shared constants and helpers for the clock-enable divider.
//   DIV_W_DEF       - default width of a divide field
//   LOCK_CYCLES_DEF - default settle time before LOCK asserts
//   div_ratio()     - turns a divide field into its actual ratio
//   lock_cnt_width()- number of bits the lock counter needs
package ccc_pkg;

  localparam int DIV_W_DEF       = 5;
  localparam int LOCK_CYCLES_DEF = 64;

  // A field of N divides by N+1, so field 0 means "every cycle".
  function automatic int unsigned div_ratio(input int unsigned field);
    return field + 1;
  endfunction

  // The lock counter must be able to hold LOCK_CYCLES itself.
  function automatic int lock_cnt_width(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

  localparam int LOCK_CNT_W_DEF = lock_cnt_width(LOCK_CYCLES_DEF);

endpackage

// File: rtl/ccc_div_channel.sv
// ccc_div_channel: one divider channel producing a one-cycle enable strobe.
// Ports:
//   clk, reset      - fabric clock, synchronous active-high reset
//   ch_en           - run enable; while low the counter is held at full period
//   div_we, div_val - write a new divide field (queued as pending)
//   ce              - registered enable strobe, one cycle per period
//   div_ack         - registered pulse when the pending field takes effect
//   pv              - pending-valid flag, used by the top for LOCK
module ccc_div_channel
  import ccc_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DIV_RESET = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_en,
  input  logic             div_we,
  input  logic [DIV_W-1:0] div_val,
  output logic             ce,
  output logic             div_ack,
  output logic             pv
);

  localparam logic [DIV_W-1:0] RST_FIELD = DIV_W'(DIV_RESET);

  logic [DIV_W-1:0] act;
  logic [DIV_W-1:0] pend;
  logic [DIV_W-1:0] cnt;
  logic             at_terminal;
  logic             apply;

  // A pending ratio is only taken at the terminal count (or at once when the
  // channel is stopped) so a period in flight is never cut short.
  assign at_terminal = ch_en && (cnt == '0);
  assign apply       = pv && (!ch_en || at_terminal);

  // Counter, ratio registers and registered strobes. A write in the same
  // cycle as an apply re-arms pv with the new value after the old one is
  // consumed, so the later write is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      act     <= RST_FIELD;
      pend    <= RST_FIELD;
      cnt     <= RST_FIELD;
      pv      <= 1'b0;
      ce      <= 1'b0;
      div_ack <= 1'b0;
    end else begin
      ce      <= at_terminal;
      div_ack <= apply;

      if (apply) begin
        act <= pend;
        cnt <= pend;
      end else if (!ch_en || at_terminal) begin
        cnt <= act;
      end else begin
        cnt <= cnt - 1'b1;
      end

      if (div_we) begin
        pend <= div_val;
        pv   <= 1'b1;
      end else if (apply) begin
        pv <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ccc_ce_divider.sv
// ccc_ce_divider: multi-channel clock-enable generator with glitch-free
// run-time ratio changes and a LOCK flag.
// Ports:
//   CLK, RESET - fabric clock, synchronous active-high reset
//   CH_EN      - per-channel run enable
//   DIV_WE     - per-channel write strobe for DIV_VAL
//   DIV_VAL    - new divide field, shared by all channels
//   CE         - per-channel registered enable strobe
//   DIV_ACK    - per-channel pulse when a new ratio takes effect
//   LOCK       - all ratios applied and stable for LOCK_CYCLES cycles
module ccc_ce_divider
  import ccc_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_RESET   = 3,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic [NUM_CH-1:0] DIV_WE,
  input  logic [DIV_W-1:0]  DIV_VAL,
  output logic [NUM_CH-1:0] CE,
  output logic [NUM_CH-1:0] DIV_ACK,
  output logic              LOCK
);

  localparam int                LCW      = lock_cnt_width(LOCK_CYCLES);
  localparam logic [LCW-1:0]    LOCK_MAX = LCW'(LOCK_CYCLES);

  logic [NUM_CH-1:0] pv_vec;
  logic              any_pv;
  logic [LCW-1:0]    lock_cnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ccc_div_channel #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk     (CLK),
      .reset   (RESET),
      .ch_en   (CH_EN[i]),
      .div_we  (DIV_WE[i]),
      .div_val (DIV_VAL),
      .ce      (CE[i]),
      .div_ack (DIV_ACK[i]),
      .pv      (pv_vec[i])
    );
  end

  assign any_pv = |pv_vec;

  // Settle counter: any outstanding write restarts it and drops LOCK in the
  // same edge, so LOCK falls the cycle after a write lands.
  always_ff @(posedge CLK) begin
    if (RESET || any_pv) begin
      lock_cnt <= '0;
      LOCK     <= 1'b0;
    end else begin
      if (lock_cnt != LOCK_MAX) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      LOCK <= (lock_cnt == LOCK_MAX);
    end
  end

endmodule
